// File: rtl/rv32_fetch_stage.sv
// RV32 instruction fetch stage: credit-limited request issue, in-order address
// tracking, 2-entry output FIFO toward decode and branch redirect with response draining.
module rv32_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        do_branch,
   input  logic [31:0] branch_target,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        dec_ready
);

   typedef enum logic {BOOT, FETCH} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [1:0]  outstanding;
   logic [1:0]  drop_count;

   logic [31:0] aq_addr [2];
   logic        aq_wr;
   logic        aq_rd;

   logic [31:0] fq_instr [2];
   logic [31:0] fq_pc [2];
   logic        fq_wr;
   logic        fq_rd;
   logic [1:0]  fq_count;

   logic        credit;
   logic        issue;
   logic        rsp_keep;
   logic        fq_pop;
   logic [1:0]  outstanding_after_rsp;
   logic        unused_target_bits;

   assign unused_target_bits = ^branch_target[1:0];

   // At most two words may be in flight or buffered, so a kept response always finds room.
   assign credit         = ({1'b0, outstanding} + {1'b0, fq_count}) < 3'd2;
   assign imem_req_valid = (state == FETCH) && !do_branch && credit;
   assign imem_req_addr  = pc;
   assign issue          = imem_req_valid && imem_req_ready;

   assign rsp_keep = imem_rsp_valid && !do_branch && (drop_count == 2'd0);
   assign fq_pop   = out_valid && dec_ready && !do_branch;

   assign outstanding_after_rsp = outstanding - {1'b0, imem_rsp_valid};

   assign out_valid = (fq_count != 2'd0);
   assign out_instr = out_valid ? fq_instr[fq_rd] : 32'h0;
   assign out_pc    = out_valid ? fq_pc[fq_rd]    : 32'h0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         outstanding <= 2'd0;
         drop_count  <= 2'd0;
         aq_wr       <= 1'b0;
         aq_rd       <= 1'b0;
         fq_wr       <= 1'b0;
         fq_rd       <= 1'b0;
         fq_count    <= 2'd0;
      end else begin
         state <= FETCH;

         if (do_branch)
            pc <= {branch_target[31:2], 2'b00};
         else if (issue)
            pc <= pc + 32'd4;

         if (issue)
            aq_wr <= ~aq_wr;
         if (imem_rsp_valid)
            aq_rd <= ~aq_rd;
         outstanding <= outstanding_after_rsp + {1'b0, issue};

         // Everything still in flight after this cycle's response belongs to the old path.
         if (do_branch)
            drop_count <= outstanding_after_rsp;
         else if (imem_rsp_valid && (drop_count != 2'd0))
            drop_count <= drop_count - 2'd1;

         if (do_branch) begin
            fq_wr    <= 1'b0;
            fq_rd    <= 1'b0;
            fq_count <= 2'd0;
         end else begin
            if (rsp_keep)
               fq_wr <= ~fq_wr;
            if (fq_pop)
               fq_rd <= ~fq_rd;
            fq_count <= fq_count + {1'b0, rsp_keep} - {1'b0, fq_pop};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (issue)
         aq_addr[aq_wr] <= pc;
      if (rsp_keep) begin
         fq_instr[fq_wr] <= imem_rsp_data;
         fq_pc[fq_wr]    <= aq_addr[aq_rd];
      end
   end

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Directed bench for rv32_fetch_stage with a one-cycle, in-order instruction memory model.
module tb_rv32_fetch_stage;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b1;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        do_branch = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        dec_ready = 1'b1;

   logic        hold = 1'b0;
   logic [31:0] mq[$];
   logic [31:0] acc_log[$];

   int checks = 0;
   int errors = 0;

   rv32_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .resetn(resetn),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .do_branch(do_branch),
      .branch_target(branch_target), .out_valid(out_valid),
      .out_instr(out_instr), .out_pc(out_pc), .dec_ready(dec_ready)
   );

   always #5 clk = ~clk;

   // Memory returns addr ^ 32'hDEAD_0000 one cycle after acceptance, unless held.
   always @(posedge clk) begin
      if (!resetn) begin
         mq.delete();
         acc_log.delete();
      end else if (imem_req_valid && imem_req_ready) begin
         mq.push_back(imem_req_addr);
         acc_log.push_back(imem_req_addr);
      end
      #1;
      if (resetn && !hold && mq.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mq.pop_front() ^ 32'hDEAD_0000;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      do_branch = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks += 5;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b required=0", imem_req_valid); end
      if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got=%h required=00000000", imem_req_addr); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
      if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got=%h required=00000000", out_instr); end
      if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got=%h required=00000000", out_pc); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
      logic [31:0] exp_in [3] = '{32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_0008};
      int got = 0;
      hold = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
      do_reset();
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL seq_boot_valid got=%b required=0", imem_req_valid); end
      @(negedge clk); #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++; $display("FAIL seq_first_req got=%b/%h required=1/00000000", imem_req_valid, imem_req_addr);
      end
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clk); #1;
         if (out_valid) begin
            checks++;
            if (out_pc !== exp_pc[got] || out_instr !== exp_in[got]) begin
               errors++; $display("FAIL seq_out%0d got=%h/%h required=%h/%h", got, out_pc, out_instr, exp_pc[got], exp_in[got]);
            end
            got++;
         end
      end
      checks++;
      if (got != 3) begin errors++; $display("FAIL seq_timeout got=%0d required=3", got); end
      checks++;
      if (acc_log.size() < 3) begin
         errors++; $display("FAIL seq_req_log got=%0d entries required>=3", acc_log.size());
      end else if (acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
         errors++; $display("FAIL seq_req_log got=%h,%h required=00000004,00000008", acc_log[1], acc_log[2]);
      end
   endtask

   task automatic test_ready_stall();
      hold = 1'b0; imem_req_ready = 1'b0; dec_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++; $display("FAIL stall_hold%0d got=%b/%h required=1/00000000", c, imem_req_valid, imem_req_addr);
         end
      end
      imem_req_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (imem_req_addr !== 32'h4) begin errors++; $display("FAIL stall_advance got=%h required=00000004", imem_req_addr); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      int got = 0;
      hold = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); #1;
         if (c >= 4) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_no_req%0d got=%b required=0", c, imem_req_valid); end
         end
      end
      checks++;
      if (acc_log.size() != 2) begin errors++; $display("FAIL bp_issued got=%0d required=2", acc_log.size()); end
      dec_ready = 1'b1;
      for (int c = 0; c < 20 && got < 4; c++) begin
         if (c > 0) begin @(negedge clk); #1; end
         if (out_valid) begin
            checks++;
            if (out_pc !== exp_pc[got] || out_instr !== (exp_pc[got] ^ 32'hDEAD_0000)) begin
               errors++; $display("FAIL bp_out%0d got=%h/%h required pc=%h", got, out_pc, out_instr, exp_pc[got]);
            end
            got++;
         end
      end
      checks++;
      if (got != 4) begin errors++; $display("FAIL bp_timeout got=%0d required=4", got); end
   endtask

   task automatic test_branch_drop();
      int got = 0;
      hold = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1;
      do_reset();
      do_branch = 1'b1; branch_target = 32'h10;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL br_boot_valid got=%b required=0", imem_req_valid); end
      @(negedge clk); do_branch = 1'b0; #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
         errors++; $display("FAIL br_req10 got=%b/%h required=1/00000010", imem_req_valid, imem_req_addr);
      end
      @(negedge clk); #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h14) begin
         errors++; $display("FAIL br_req14 got=%b/%h required=1/00000014", imem_req_valid, imem_req_addr);
      end
      @(negedge clk); #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL br_credit got=%b required=0", imem_req_valid); end
      do_branch = 1'b1; branch_target = 32'h103;
      @(negedge clk); do_branch = 1'b0; hold = 1'b0;
      for (int c = 0; c < 20 && got < 1; c++) begin
         @(negedge clk); #1;
         if (out_valid) begin
            checks++;
            if (out_pc !== 32'h100 || out_instr !== 32'hDEAD_0100) begin
               errors++; $display("FAIL br_first_out got=%h/%h required=00000100/dead0100", out_pc, out_instr);
            end
            got++;
         end
      end
      checks++;
      if (got != 1) begin errors++; $display("FAIL br_timeout got=%0d required=1", got); end
      checks++;
      if (acc_log.size() < 3 || acc_log[2] !== 32'h100) begin
         errors++; $display("FAIL br_next_req got=%0d entries required third=00000100", acc_log.size());
      end
   endtask

   task automatic test_branch_coincident();
      int got = 0;
      hold = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b0;
      do_reset();
      @(negedge clk); #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++; $display("FAIL co_req0 got=%b/%h required=1/00000000", imem_req_valid, imem_req_addr);
      end
      @(negedge clk);
      do_branch = 1'b1; branch_target = 32'h200;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL co_redirect_valid got=%b required=0", imem_req_valid); end
      @(negedge clk); do_branch = 1'b0; #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         errors++; $display("FAIL co_req200 got=%b/%h required=1/00000200", imem_req_valid, imem_req_addr);
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL co_dropped got=%b required=0", out_valid); end
      checks++;
      if (acc_log.size() != 1) begin errors++; $display("FAIL co_issued got=%0d required=1", acc_log.size()); end
      dec_ready = 1'b1;
      for (int c = 0; c < 20 && got < 1; c++) begin
         @(negedge clk); #1;
         if (out_valid) begin
            checks++;
            if (out_pc !== 32'h200 || out_instr !== 32'hDEAD_0200) begin
               errors++; $display("FAIL co_first_out got=%h/%h required=00000200/dead0200", out_pc, out_instr);
            end
            got++;
         end
      end
      checks++;
      if (got != 1) begin errors++; $display("FAIL co_timeout got=%0d required=1", got); end
   endtask

   task automatic test_wrap();
      int got = 0;
      hold = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
      do_reset();
      do_branch = 1'b1; branch_target = 32'hFFFF_FFFE;
      @(negedge clk); do_branch = 1'b0; #1;
      checks++;
      if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got=%h required=fffffffc", imem_req_addr); end
      @(negedge clk); #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_zero got=%b/%h required=1/00000000", imem_req_valid, imem_req_addr);
      end
      for (int c = 0; c < 20 && got < 1; c++) begin
         @(negedge clk); #1;
         if (out_valid) begin
            checks++;
            if (out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h2152_FFFC) begin
               errors++; $display("FAIL wrap_out got=%h/%h required=fffffffc/2152fffc", out_pc, out_instr);
            end
            got++;
         end
      end
      checks++;
      if (got != 1) begin errors++; $display("FAIL wrap_timeout got=%0d required=1", got); end
   endtask

   task automatic test_reset_midop();
      logic [31:0] exp_pc [2] = '{32'h0, 32'h4};
      int got = 0;
      hold = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b0;
      do_reset();
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got=%b required=1", out_valid); end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0) begin
         errors++; $display("FAIL mid_async got=%b/%h/%b/%h/%h required=0/00000000/0/00000000/00000000",
                            imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1; dec_ready = 1'b1;
      for (int c = 0; c < 20 && got < 2; c++) begin
         @(negedge clk); #1;
         if (out_valid) begin
            checks++;
            if (out_pc !== exp_pc[got] || out_instr !== (exp_pc[got] ^ 32'hDEAD_0000)) begin
               errors++; $display("FAIL mid_out%0d got=%h/%h required pc=%h", got, out_pc, out_instr, exp_pc[got]);
            end
            got++;
         end
      end
      checks++;
      if (got != 2) begin errors++; $display("FAIL mid_timeout got=%0d required=2", got); end
      checks++;
      if (acc_log.size() < 1 || acc_log[0] !== 32'h0) begin
         errors++; $display("FAIL mid_restart got=%0d entries required first=00000000", acc_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_ready_stall();
      test_backpressure();
      test_branch_drop();
      test_branch_coincident();
      test_wrap();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
